// File: rtl/coolgirl_irq_pkg.sv
// Shared encodings for the CoolGirl mapper IRQ unit: counter modes,
// register-select addresses and control-register bit positions.
package coolgirl_irq_pkg;

    typedef enum logic [1:0] {
        MODE_OFF  = 2'd0,
        MODE_MMC3 = 2'd1,
        MODE_FME7 = 2'd2,
        MODE_VRC4 = 2'd3
    } irq_mode_e;

    localparam logic [2:0] SEL_MODE     = 3'd0;
    localparam logic [2:0] SEL_LATCH_LO = 3'd1;
    localparam logic [2:0] SEL_LATCH_HI = 3'd2;
    localparam logic [2:0] SEL_CTRL     = 3'd3;
    localparam logic [2:0] SEL_RELOAD   = 3'd4;
    localparam logic [2:0] SEL_ACK      = 3'd5;

    // Bit 1 means "count enable" on FME-7 and "enable-after-ack" on VRC4.
    localparam int CTRL_EN     = 0;
    localparam int CTRL_CNT_EN = 1;
    localparam int CTRL_EN_ACK = 1;
    localparam int CTRL_CYCLE  = 2;

endpackage

// File: rtl/coolgirl_a12_filter.sv
// Synchronises PPU A12 into the m2 domain and emits a one-cycle pulse on a
// rising edge that followed at least A12_FILTER low cycles.
module coolgirl_a12_filter #(
    parameter int A12_FILTER = 3
) (
    input  logic m2,
    input  logic reset_n,
    input  logic clr,
    input  logic ppu_a12,
    output logic edge_pulse
);

    localparam int LW = $clog2(A12_FILTER + 1);
    localparam logic [LW-1:0] FILT = LW'(A12_FILTER);

    logic          sync1_q, sync2_q, prev_q;
    logic [LW-1:0] low_q, low_d;

    always_comb begin
        low_d = low_q;
        if (clr || sync2_q) begin
            low_d = '0;
        end else if (low_q != FILT) begin
            low_d = low_q + LW'(1);
        end
    end

    always_ff @(posedge m2 or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            low_q   <= '0;
        end else begin
            sync1_q <= ppu_a12;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            low_q   <= low_d;
        end
    end

    assign edge_pulse = sync2_q && !prev_q && (low_q == FILT);

endmodule

// File: rtl/coolgirl_irq_unit.sv
// Multi-mapper IRQ generator: MMC3 scanline counter, FME-7 CPU-cycle
// down-counter and VRC4 prescaled up-counter sharing one counter/latch pair.
module coolgirl_irq_unit
    import coolgirl_irq_pkg::*;
#(
    parameter int CNT_WIDTH  = 16,
    parameter int A12_FILTER = 3,
    parameter int PRESCALE   = 341
) (
    input  logic       m2,
    input  logic       reset_n,
    input  logic       reg_we,
    input  logic [2:0] reg_sel,
    input  logic [7:0] reg_data,
    input  logic       ppu_a12,
    output logic       irq
);

    localparam int PW = $clog2(PRESCALE + 3);
    localparam logic [PW-1:0] PRESC = PW'(PRESCALE);

    irq_mode_e            mode_q, mode_d;
    logic [CNT_WIDTH-1:0] latch_q, latch_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [2:0]           ctrl_q, ctrl_d;
    logic [PW-1:0]        presc_q, presc_d;
    logic                 reload_q, reload_d;
    logic                 irq_q, irq_d;

    logic          a12_pulse, filt_clr, wr_blocks, tick;
    logic [7:0]    nxt8;
    logic [PW-1:0] psum;

    function automatic logic [CNT_WIDTH-1:0] set_lo(input logic [CNT_WIDTH-1:0] v,
                                                    input logic [7:0] b);
        logic [CNT_WIDTH-1:0] r;
        r      = v;
        r[7:0] = b;
        return r;
    endfunction

    // Widened so bits [15:8] exist even at the minimum CNT_WIDTH of 8.
    function automatic logic [CNT_WIDTH-1:0] set_hi(input logic [CNT_WIDTH-1:0] v,
                                                    input logic [7:0] b);
        logic [CNT_WIDTH+7:0] w;
        w       = {8'h00, v};
        w[15:8] = b;
        return w[CNT_WIDTH-1:0];
    endfunction

    coolgirl_a12_filter #(
        .A12_FILTER(A12_FILTER)
    ) u_a12_filter (
        .m2        (m2),
        .reset_n   (reset_n),
        .clr       (filt_clr),
        .ppu_a12   (ppu_a12),
        .edge_pulse(a12_pulse)
    );

    always_comb begin
        mode_d    = mode_q;
        latch_d   = latch_q;
        cnt_d     = cnt_q;
        ctrl_d    = ctrl_q;
        presc_d   = presc_q;
        reload_d  = reload_q;
        irq_d     = irq_q;
        filt_clr  = 1'b0;
        tick      = 1'b0;
        nxt8      = 8'h00;
        psum      = presc_q + PW'(3);
        // Acknowledge does not block counter events so a coincident irq-set wins.
        wr_blocks = reg_we && (reg_sel <= SEL_RELOAD);

        if (reg_we) begin
            case (reg_sel)
                SEL_MODE: begin
                    mode_d   = irq_mode_e'(reg_data[1:0]);
                    irq_d    = 1'b0;
                    presc_d  = '0;
                    reload_d = 1'b0;
                    filt_clr = 1'b1;
                end
                SEL_LATCH_LO: begin
                    latch_d = set_lo(latch_q, reg_data);
                    if (mode_q == MODE_FME7) cnt_d = set_lo(cnt_q, reg_data);
                end
                SEL_LATCH_HI: begin
                    latch_d = set_hi(latch_q, reg_data);
                    if (mode_q == MODE_FME7) cnt_d = set_hi(cnt_q, reg_data);
                end
                SEL_CTRL: begin
                    ctrl_d = reg_data[2:0];
                    if (mode_q == MODE_MMC3 && !reg_data[CTRL_EN]) irq_d = 1'b0;
                    if (mode_q == MODE_VRC4) begin
                        if (reg_data[CTRL_EN]) cnt_d = set_lo(cnt_q, latch_q[7:0]);
                        presc_d = '0;
                        irq_d   = 1'b0;
                    end
                end
                SEL_RELOAD: begin
                    if (mode_q == MODE_MMC3) begin
                        reload_d = 1'b1;
                        cnt_d    = set_lo(cnt_q, 8'h00);
                    end
                end
                SEL_ACK: begin
                    irq_d = 1'b0;
                    if (mode_q == MODE_VRC4) ctrl_d[CTRL_EN] = ctrl_q[CTRL_EN_ACK];
                end
                default: ;
            endcase
        end

        if (!wr_blocks) begin
            case (mode_q)
                MODE_MMC3: begin
                    if (a12_pulse) begin
                        if (cnt_q[7:0] == 8'h00 || reload_q) begin
                            nxt8     = latch_q[7:0];
                            reload_d = 1'b0;
                        end else begin
                            nxt8 = cnt_q[7:0] - 8'd1;
                        end
                        cnt_d = set_lo(cnt_q, nxt8);
                        if (nxt8 == 8'h00 && ctrl_q[CTRL_EN]) irq_d = 1'b1;
                    end
                end
                MODE_FME7: begin
                    if (ctrl_q[CTRL_CNT_EN]) begin
                        cnt_d = cnt_q - CNT_WIDTH'(1);
                        if (cnt_q == '0 && ctrl_q[CTRL_EN]) irq_d = 1'b1;
                    end
                end
                MODE_VRC4: begin
                    if (ctrl_q[CTRL_CYCLE]) begin
                        tick = 1'b1;
                    end else if (psum >= PRESC) begin
                        presc_d = psum - PRESC;
                        tick    = 1'b1;
                    end else begin
                        presc_d = psum;
                    end
                    if (tick) begin
                        if (cnt_q[7:0] == 8'hFF) begin
                            cnt_d = set_lo(cnt_q, latch_q[7:0]);
                            if (ctrl_q[CTRL_EN]) irq_d = 1'b1;
                        end else begin
                            cnt_d = set_lo(cnt_q, cnt_q[7:0] + 8'd1);
                        end
                    end
                end
                default: ;
            endcase
        end

        if (mode_q == MODE_OFF) irq_d = 1'b0;
    end

    always_ff @(posedge m2 or negedge reset_n) begin
        if (!reset_n) begin
            mode_q   <= MODE_OFF;
            latch_q  <= '0;
            cnt_q    <= '0;
            ctrl_q   <= '0;
            presc_q  <= '0;
            reload_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            mode_q   <= mode_d;
            latch_q  <= latch_d;
            cnt_q    <= cnt_d;
            ctrl_q   <= ctrl_d;
            presc_q  <= presc_d;
            reload_q <= reload_d;
            irq_q    <= irq_d;
        end
    end

    assign irq = irq_q;

endmodule

// File: tb/tb_coolgirl_irq_unit.sv
// Self-checking bench for coolgirl_irq_unit: register-write vector table,
// MMC3 A12 sequences, VRC4 prescaler timing and asynchronous reset.
module tb_coolgirl_irq_unit;

    logic       m2 = 1'b0;
    logic       reset_n = 1'b0;
    logic       reg_we = 1'b0;
    logic [2:0] reg_sel = 3'd0;
    logic [7:0] reg_data = 8'h00;
    logic       ppu_a12 = 1'b0;
    logic       irq;

    int checks = 0;
    int errors = 0;
    logic cur_irq = 1'b0;

    coolgirl_irq_unit dut (
        .m2      (m2),
        .reset_n (reset_n),
        .reg_we  (reg_we),
        .reg_sel (reg_sel),
        .reg_data(reg_data),
        .ppu_a12 (ppu_a12),
        .irq     (irq)
    );

    always #5 m2 = ~m2;

    typedef struct {
        logic        irq;
        logic        chk_cnt;
        logic [15:0] cnt;
    } exp_t;

    typedef struct {
        logic        we;
        logic [2:0]  sel;
        logic [7:0]  data;
        logic        exp_irq;
        logic        chk_cnt;
        logic [15:0] exp_cnt;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic add(input logic we, input logic [2:0] sel, input logic [7:0] data,
                       input logic e_irq, input logic chk, input logic [15:0] e_cnt);
        vec_t v;
        v.we = we; v.sel = sel; v.data = data;
        v.exp_irq = e_irq; v.chk_cnt = chk; v.exp_cnt = e_cnt;
        vecs.push_back(v);
    endtask

    // One m2 cycle: drive, queue the expectation, sample 1 time unit after the edge.
    task automatic step(input logic we, input logic [2:0] sel, input logic [7:0] data,
                        input logic a12, input logic e_irq, input logic chk,
                        input logic [15:0] e_cnt, input string nm);
        exp_t e;
        reg_we = we; reg_sel = sel; reg_data = data; ppu_a12 = a12;
        e.irq = e_irq; e.chk_cnt = chk; e.cnt = e_cnt;
        sb.push_back(e);
        @(posedge m2);
        #1;
        e = sb.pop_front();
        check({nm, " irq"}, 32'(irq), 32'(e.irq));
        if (e.chk_cnt) check({nm, " cnt"}, 32'(dut.cnt_q), 32'(e.cnt));
    endtask

    task automatic mmc3_edge(input int low_n, input logic irq_after,
                             input logic [15:0] cnt_after, input string nm);
        for (int i = 0; i < low_n; i++) step(1'b0, 3'd0, 8'h00, 1'b0, cur_irq, 1'b0, 16'h0, nm);
        step(1'b0, 3'd0, 8'h00, 1'b1, cur_irq, 1'b0, 16'h0, nm);
        step(1'b0, 3'd0, 8'h00, 1'b1, cur_irq, 1'b0, 16'h0, nm);
        step(1'b0, 3'd0, 8'h00, 1'b1, irq_after, 1'b1, cnt_after, nm);
        cur_irq = irq_after;
    endtask

    initial begin
        int rise[$];
        logic ack_next;
        int exp_rise[3];
        exp_rise[0] = 114; exp_rise[1] = 228; exp_rise[2] = 341;

        // FME-7: count 2 -> 1 -> 0 -> FFFF with irq
        add(1, 3'd0, 8'h02, 0, 0, 16'h0);
        add(1, 3'd1, 8'h02, 0, 0, 16'h0);
        add(1, 3'd2, 8'h00, 0, 1, 16'h0002);
        add(1, 3'd3, 8'h03, 0, 1, 16'h0002);
        add(0, 3'd0, 8'h00, 0, 1, 16'h0001);
        add(0, 3'd0, 8'h00, 0, 1, 16'h0000);
        add(0, 3'd0, 8'h00, 1, 1, 16'hFFFF);
        add(0, 3'd0, 8'h00, 1, 1, 16'hFFFE);
        add(1, 3'd5, 8'h00, 0, 1, 16'hFFFD);
        add(1, 3'd3, 8'h00, 0, 1, 16'hFFFD);
        // FME-7: acknowledge coincident with wrap leaves irq set
        add(1, 3'd1, 8'h01, 0, 1, 16'hFF01);
        add(1, 3'd2, 8'h00, 0, 1, 16'h0001);
        add(1, 3'd3, 8'h03, 0, 0, 16'h0);
        add(0, 3'd0, 8'h00, 0, 1, 16'h0000);
        add(1, 3'd5, 8'h00, 1, 1, 16'hFFFF);
        add(1, 3'd5, 8'h00, 0, 1, 16'hFFFE);
        // FME-7: a latch write at wrap time discards the wrap
        add(1, 3'd3, 8'h00, 0, 1, 16'hFFFE);
        add(1, 3'd1, 8'h01, 0, 0, 16'h0);
        add(1, 3'd2, 8'h00, 0, 0, 16'h0);
        add(1, 3'd3, 8'h03, 0, 1, 16'h0001);
        add(0, 3'd0, 8'h00, 0, 1, 16'h0000);
        add(1, 3'd1, 8'h05, 0, 1, 16'h0005);
        add(0, 3'd0, 8'h00, 0, 1, 16'h0004);
        // VRC4 cycle mode
        add(1, 3'd0, 8'h03, 0, 1, 16'h0004);
        add(1, 3'd1, 8'hFE, 0, 1, 16'h0004);
        add(1, 3'd3, 8'h05, 0, 1, 16'h00FE);
        add(0, 3'd0, 8'h00, 0, 1, 16'h00FF);
        add(0, 3'd0, 8'h00, 1, 1, 16'h00FE);
        add(1, 3'd5, 8'h00, 0, 1, 16'h00FF);
        add(0, 3'd0, 8'h00, 0, 1, 16'h00FE);
        add(0, 3'd0, 8'h00, 0, 0, 16'h0);
        add(0, 3'd0, 8'h00, 0, 0, 16'h0);
        // Mode off: counter holds
        add(1, 3'd0, 8'h00, 0, 1, 16'h00FE);
        add(0, 3'd0, 8'h00, 0, 1, 16'h00FE);
        add(0, 3'd0, 8'h00, 0, 1, 16'h00FE);

        repeat (3) @(posedge m2);
        #1;
        check("reset irq", 32'(irq), 32'd0);
        check("reset cnt", 32'(dut.cnt_q), 32'd0);
        @(negedge m2);
        reset_n = 1'b1;
        @(posedge m2);
        #1;

        foreach (vecs[i]) begin
            step(vecs[i].we, vecs[i].sel, vecs[i].data, 1'b0, vecs[i].exp_irq,
                 vecs[i].chk_cnt, vecs[i].exp_cnt, $sformatf("vec[%0d]", i));
        end

        // MMC3: latch 3, reload, four qualified edges -> 3,2,1,0 with irq on the last
        step(1, 3'd0, 8'h01, 1'b0, 1'b0, 1'b0, 16'h0, "mmc3 mode");
        step(1, 3'd1, 8'h03, 1'b0, 1'b0, 1'b0, 16'h0, "mmc3 latch");
        step(1, 3'd4, 8'h00, 1'b0, 1'b0, 1'b1, 16'h0000, "mmc3 reload");
        step(1, 3'd3, 8'h01, 1'b0, 1'b0, 1'b0, 16'h0, "mmc3 ctrl");
        cur_irq = 1'b0;
        mmc3_edge(4, 1'b0, 16'h0003, "mmc3 e1");
        mmc3_edge(4, 1'b0, 16'h0002, "mmc3 e2");
        mmc3_edge(4, 1'b0, 16'h0001, "mmc3 e3");
        mmc3_edge(4, 1'b1, 16'h0000, "mmc3 e4");
        step(1, 3'd3, 8'h00, 1'b1, 1'b0, 1'b0, 16'h0, "mmc3 disable");
        cur_irq = 1'b0;

        // MMC3: edges after only 2 low cycles are ignored
        step(1, 3'd3, 8'h01, 1'b1, 1'b0, 1'b0, 16'h0, "glitch ctrl");
        step(1, 3'd1, 8'h01, 1'b1, 1'b0, 1'b0, 16'h0, "glitch latch");
        step(1, 3'd4, 8'h00, 1'b1, 1'b0, 1'b1, 16'h0000, "glitch reload");
        mmc3_edge(2, 1'b0, 16'h0000, "glitch g1");
        mmc3_edge(2, 1'b0, 16'h0000, "glitch g2");
        mmc3_edge(2, 1'b0, 16'h0000, "glitch g3");
        mmc3_edge(3, 1'b0, 16'h0001, "glitch q1");
        mmc3_edge(3, 1'b1, 16'h0000, "glitch q2");

        // Asynchronous reset while irq is high
        @(negedge m2);
        reset_n = 1'b0;
        #1;
        check("arst irq", 32'(irq), 32'd0);
        check("arst mode", 32'(dut.mode_q), 32'd0);
        check("arst cnt", 32'(dut.cnt_q), 32'd0);
        check("arst latch", 32'(dut.latch_q), 32'd0);
        check("arst ctrl", 32'(dut.ctrl_q), 32'd0);
        check("arst reload", 32'(dut.reload_q), 32'd0);
        @(negedge m2);
        reset_n = 1'b1;
        @(posedge m2);
        #1;

        // VRC4 prescaled: latch FF, ticks at 114, 228, 341 m2 after the control write
        step(1, 3'd0, 8'h03, 1'b0, 1'b0, 1'b0, 16'h0, "vrc4p mode");
        step(1, 3'd1, 8'hFF, 1'b0, 1'b0, 1'b0, 16'h0, "vrc4p latch");
        step(1, 3'd3, 8'h03, 1'b0, 1'b0, 1'b1, 16'h00FF, "vrc4p ctrl");
        ack_next = 1'b0;
        for (int i = 1; i <= 350; i++) begin
            reg_we = ack_next; reg_sel = 3'd5; reg_data = 8'h00;
            @(posedge m2);
            #1;
            ack_next = 1'b0;
            if (irq) begin
                rise.push_back(i);
                ack_next = 1'b1;
            end
        end
        reg_we = 1'b0;
        check("vrc4p ticks", 32'(rise.size()), 32'd3);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("vrc4p tick%0d", k),
                  (k < rise.size()) ? 32'(rise[k]) : 32'hFFFF_FFFF, 32'(exp_rise[k]));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
